// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and data
// requesters, running one IDLE -> ACCESS -> RESP transaction at a time with a timeout watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter bit RR_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_rd_wr,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_data_q, last_data_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_done_q, if_done_d, d_done_q, d_done_d;
    logic              mem_req_q, mem_req_d, mem_rd_wr_q, mem_rd_wr_d;
    logic              err_timeout_q, err_timeout_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              any_req, pick_data, timeout_hit;

    // last_data_q doubles as the current owner once a grant has been made.
    assign any_req     = if_req | d_req;
    assign pick_data   = d_req & ~(if_req & RR_EN & last_data_q);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        last_data_d   = last_data_q;
        if_gnt_d      = if_gnt_q;
        d_gnt_d       = d_gnt_q;
        if_done_d     = if_done_q;
        d_done_d      = d_done_q;
        mem_req_d     = mem_req_q;
        mem_rd_wr_d   = mem_rd_wr_q;
        err_timeout_d = err_timeout_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    mem_req_d   = 1'b1;
                    if_gnt_d    = ~pick_data;
                    d_gnt_d     = pick_data;
                    cnt_d       = '0;
                    last_data_d = pick_data;
                    if (pick_data) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_rd_wr_d = d_rd_wr;
                    end else begin
                        mem_addr_d  = if_addr;
                        mem_rd_wr_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // A ready on the final watchdog cycle still completes normally.
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (last_data_q) begin
                        d_done_d = 1'b1;
                        if (mem_rd_wr_q) d_rdata_d = mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    mem_req_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    if (last_data_q) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if_gnt_d  = 1'b0;
                d_gnt_d   = 1'b0;
                if_done_d = 1'b0;
                d_done_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            last_data_q   <= 1'b1;
            if_gnt_q      <= 1'b0;
            d_gnt_q       <= 1'b0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_rd_wr_q   <= 1'b1;
            err_timeout_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
        end else begin
            cnt_q         <= cnt_d;
            last_data_q   <= last_data_d;
            if_gnt_q      <= if_gnt_d;
            d_gnt_q       <= d_gnt_d;
            if_done_q     <= if_done_d;
            d_done_q      <= d_done_d;
            mem_req_q     <= mem_req_d;
            mem_rd_wr_q   <= mem_rd_wr_d;
            err_timeout_q <= err_timeout_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign if_gnt      = if_gnt_q;
    assign d_gnt       = d_gnt_q;
    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign mem_req     = mem_req_q;
    assign mem_rd_wr   = mem_rd_wr_q;
    assign err_timeout = err_timeout_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
endmodule
